// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module      : mdu_ctrl
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic           r_busy;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;
    logic [31:0]    r_pend_hi;
    logic [31:0]    r_pend_lo;
    logic           r_pend_wr;

    logic           w_is_mult;
    logic           w_is_div;
    logic           w_mul_signed;
    logic [63:0]    w_mul_a;
    logic [63:0]    w_mul_b;
    logic [63:0]    w_product;
    logic           w_div_signed;
    logic           w_div_by_zero;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [31:0]    w_a_mag;
    logic [31:0]    w_b_mag;
    logic [31:0]    w_q_mag;
    logic [31:0]    w_r_mag;
    logic [31:0]    w_quot;
    logic [31:0]    w_rem;

    assign w_is_mult = (op == c_OP_MULT) || (op == c_OP_MULTU);
    assign w_is_div  = (op == c_OP_DIV)  || (op == c_OP_DIVU);

    // One shared 64-bit multiplier; sign- or zero-extension selects mult vs multu.
    assign w_mul_signed = (op == c_OP_MULT);
    assign w_mul_a      = {{32{w_mul_signed & a[31]}}, a};
    assign w_mul_b      = {{32{w_mul_signed & b[31]}}, b};
    assign w_product    = w_mul_a * w_mul_b;

    // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_div_signed  = (op == c_OP_DIV);
    assign w_div_by_zero = (b == 32'd0);
    assign w_a_neg       = w_div_signed & a[31];
    assign w_b_neg       = w_div_signed & b[31];
    assign w_a_mag       = w_a_neg ? (~a + 32'd1) : a;
    assign w_b_mag       = w_div_by_zero ? 32'd1 : (w_b_neg ? (~b + 32'd1) : b);
    assign w_q_mag       = w_a_mag / w_b_mag;
    assign w_r_mag       = w_a_mag % w_b_mag;
    assign w_quot        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem         = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (w_is_mult) begin
                            r_state   <= S_BUSY;
                            r_busy    <= 1'b1;
                            r_count   <= CW'(MULT_CYCLES);
                            r_pend_hi <= w_product[63:32];
                            r_pend_lo <= w_product[31:0];
                            r_pend_wr <= 1'b1;
                        end else if (w_is_div) begin
                            r_state   <= S_BUSY;
                            r_busy    <= 1'b1;
                            r_count   <= CW'(DIV_CYCLES);
                            r_pend_hi <= w_rem;
                            r_pend_lo <= w_quot;
                            r_pend_wr <= !w_div_by_zero;
                        end else if (op == c_OP_MTHI) begin
                            r_hi <= a;
                        end else if (op == c_OP_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                S_BUSY: begin
                    // New starts are ignored here; flush beats completion.
                    if (flush) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_count   <= '0;
                        r_pend_wr <= 1'b0;
                    end else if (r_count == CW'(1)) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_count   <= '0;
                        r_pend_wr <= 1'b0;
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Self-checking bench for mdu_ctrl against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .flush(flush),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    function automatic int exp_cycles(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MULT_CYCLES;
        if (o == 3'd3 || o == 3'd4) return DIV_CYCLES;
        return 0;
    endfunction

    // Architectural effect of one completed op on HI/LO.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        case (o)
            3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd3: if (y != 0) begin
                p = 64'(sa / sb); m_lo = p[31:0];
                p = 64'(sa % sb); m_hi = p[31:0];
            end
            3'd4: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            3'd5: m_hi = x;
            3'd6: m_lo = x;
            default: ;
        endcase
    endtask

    // Called on a falling edge; returns on the first falling edge with busy low.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int          n;
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
            o = (i % 2 == 0) ? 3'd1 : 3'd2;
            x = $urandom; y = $urandom;
            if (i == 0) begin x = 32'hFFFF_FFFD; y = 32'd5; end
            if (i == 1) begin x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
            run_op(o, x, y, n);
            model_apply(o, x, y);
            n_checks++; if (n != MULT_CYCLES) begin n_fail++; $display("FAIL mult_busy_len: got %0d expected %0d", n, MULT_CYCLES); end
            n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL mult_hi op%0d %h*%h: got %h expected %h", o, x, y, hi, m_hi); end
            n_checks++; if (lo !== m_lo) begin n_fail++; $display("FAIL mult_lo op%0d %h*%h: got %h expected %h", o, x, y, lo, m_lo); end
        end
    endtask

    task automatic test_div();
        int          n;
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 10; i++) begin
            o = (i % 2 == 0) ? 3'd3 : 3'd4;
            x = $urandom; y = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            if (i == 0) begin x = 32'hFFFF_FFF9; y = 32'd2; end
            if (i == 2) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            if (i == 4) begin x = 32'd17; y = 32'hFFFF_FFFB; end
            run_op(o, x, y, n);
            model_apply(o, x, y);
            n_checks++; if (n != DIV_CYCLES) begin n_fail++; $display("FAIL div_busy_len: got %0d expected %0d", n, DIV_CYCLES); end
            n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL div_hi op%0d %h/%h: got %h expected %h", o, x, y, hi, m_hi); end
            n_checks++; if (lo !== m_lo) begin n_fail++; $display("FAIL div_lo op%0d %h/%h: got %h expected %h", o, x, y, lo, m_lo); end
        end
    endtask

    task automatic test_move_divzero();
        int n;
        run_op(3'd5, 32'h1234_5678, 32'd0, n);
        model_apply(3'd5, 32'h1234_5678, 32'd0);
        n_checks++; if (n != 0) begin n_fail++; $display("FAIL mthi_busy: got %0d cycles expected 0", n); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        run_op(3'd4, 32'd7, 32'd0, n);
        n_checks++; if (n != DIV_CYCLES) begin n_fail++; $display("FAIL divzero_busy_len: got %0d expected %0d", n, DIV_CYCLES); end
        n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL divzero_hi: got %h expected %h", hi, m_hi); end
        n_checks++; if (lo !== m_lo) begin n_fail++; $display("FAIL divzero_lo: got %h expected %h", lo, m_lo); end
        foreach (op[i]) begin end
        run_op(3'd0, 32'hDEAD_BEEF, 32'd3, n);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd3, n);
        n_checks++; if (n != 0) begin n_fail++; $display("FAIL reserved_op_busy: got %0d expected 0", n); end
        n_checks++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL noop_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_flush();
        int n;
        run_op(3'd6, 32'hAAAA_0000, 32'd0, n);
        model_apply(3'd6, 32'hAAAA_0000, 32'd0);
        n_checks++; if (lo !== 32'hAAAA_0000) begin n_fail++; $display("FAIL mtlo_lo: got %h expected aaaa0000", lo); end
        // divu 100/7 flushed during busy cycle 3
        start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
        n_checks++; if (lo !== m_lo) begin n_fail++; $display("FAIL flush_lo: got %h expected %h", lo, m_lo); end
        n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL flush_hi: got %h expected %h", hi, m_hi); end
        // flush on the final busy cycle: no commit
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd9;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (MULT_CYCLES - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++; if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin n_fail++; $display("FAIL flush_last: got %b %h_%h expected 0 %h_%h", busy, hi, lo, m_hi, m_lo); end
        // flush together with start in IDLE: start dropped
        start = 1'b1; op = 3'd2; a = 32'd4; b = 32'd4; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd0; flush = 1'b0;
        n = 0;
        for (int i = 0; i < MULT_CYCLES + 1; i++) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
        end
        n_checks++; if (n != 0) begin n_fail++; $display("FAIL flush_start_busy: got %0d busy cycles expected 0", n); end
        n_checks++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL flush_start_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
        // mtlo issued while busy is a protocol violation and must be ignored
        start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 1) begin start = 1'b1; op = 3'd6; a = 32'h0BAD_0BAD; end
            else begin start = 1'b0; op = 3'd0; end
            n++;
            @(negedge clk);
        end
        start = 1'b0; op = 3'd0;
        model_apply(3'd4, 32'd100, 32'd7);
        n_checks++; if (n != DIV_CYCLES) begin n_fail++; $display("FAIL busy_start_len: got %0d expected %0d", n, DIV_CYCLES); end
        n_checks++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL busy_start_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_async_reset();
        int n;
        start = 1'b1; op = 3'd1; a = 32'd11; b = 32'd13;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL async_reset: got %b %h_%h expected 0 0_0", busy, hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        run_op(3'd1, 32'hFFFF_FFF0, 32'h0000_0100, n);
        model_apply(3'd1, 32'hFFFF_FFF0, 32'h0000_0100);
        n_checks++; if (n != MULT_CYCLES) begin n_fail++; $display("FAIL post_reset_len: got %0d expected %0d", n, MULT_CYCLES); end
        n_checks++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL post_reset_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_back_to_back();
        int          n;
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 16; i++) begin
            o = 3'($urandom_range(1, 6));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op(o, x, y, n);
            model_apply(o, x, y);
            n_checks++; if (n != exp_cycles(o)) begin n_fail++; $display("FAIL b2b_len op%0d: got %0d expected %0d", o, n, exp_cycles(o)); end
            n_checks++; if ({hi, lo} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL b2b_hilo op%0d %h,%h: got %h_%h expected %h_%h", o, x, y, hi, lo, m_hi, m_lo); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move_divzero();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and its sequencer for the pipelined MIPS CPU.
- Owns the architectural HI/LO registers.
- Executes mult/multu/div/divu with fixed configurable latency; executes mthi/mtlo in one cycle.
- Sits in the EX stage. Its busy output feeds the hazard unit, which stalls any MDU-class instruction in D while busy is high or start is asserted.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range >=1)
DIV_CYCLES, 10, busy cycles for div/divu (legal range >=1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  qualifies op this cycle
op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
a  input  32  rs operand
b  input  32  rt operand
flush  input  1  cancel in-flight mult/div (exception/branch flush)
busy  output  1  registered; high while a mult/div is in flight
hi  output  32  current HI register (direct register read, no bypass)
lo  output  32  current LO register

Behaviour:
- Reset (async, any time): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result discarded.
- States:
  - IDLE -> BUSY on start with op 1-4 and flush=0.
  - BUSY -> IDLE when counter reaches 1, or on flush.
- Start, mult/div (edge T0):
  - Result is computed from a/b sampled at T0 into pending regs; counter loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 during the N cycles after T0.
  - HI/LO written on the edge ending the last busy cycle, so the new values are visible in the same cycle busy falls.
- mthi/mtlo in IDLE: hi (or lo) <= a at the next edge; busy stays 0.
- mult: signed 64-bit product {hi,lo} = $signed(a)*$signed(b). multu: unsigned product.
- div:
  - Signed; lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (div or divu): full DIV_CYCLES busy period runs; hi/lo unchanged at completion.
- start while BUSY (any op, including mthi/mtlo): ignored, no state change. This is a hazard-unit protocol violation; the bench flags it.
- flush while BUSY: busy=0 next edge, pending result discarded, hi/lo unchanged.
- flush on the final busy cycle: flush wins; no commit.
- flush and start in the same cycle: start ignored, whatever the state.
- op 0 or 7 with start: no effect.
- Back-to-back: start may be asserted in the first cycle busy=0 after completion and sees the committed hi/lo as operands are irrelevant.

Test Plan:
- Reset, then mult a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu a=b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div -7/2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x12345678, then divu 7/0 -> hi=0x12345678 next cycle with busy=0; busy high 10 cycles; hi/lo unchanged afterwards.
- mtlo 0xAAAA0000, then divu 100/7 with flush on busy cycle 3 -> busy=0 next cycle, lo stays 0xAAAA0000. Also start mtlo while busy -> ignored.
- reset asserted mid-mult (cycle 2) -> busy, hi, lo = 0 immediately, without waiting for a clock edge; a following mult completes normally.
